// File: rtl/ray_slice_caster.sv
// rtl/ray_slice_caster.sv - per-column ray marcher producing slice height and skip flag
module ray_slice_caster #(
    parameter int MAX_STEPS = 64,
    parameter int HEIGHT_K  = 1920,
    parameter int DIV_BITS  = 12
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        begin_calc,
    input  logic [12:0] playerX,
    input  logic [12:0] playerY,
    input  logic [9:0]  ray_dx,
    input  logic [9:0]  ray_dy,
    output logic [7:0]  map_addr,
    input  logic        map_data,
    output logic [6:0]  slice_size,
    output logic        skip_this_slice,
    output logic        end_calc
);

    localparam int                  CW        = $clog2(DIV_BITS + 1);
    localparam logic [6:0]          LAST_STEP = 7'(MAX_STEPS - 1);
    localparam logic [DIV_BITS-1:0] DIVIDEND  = DIV_BITS'(HEIGHT_K);
    localparam logic [DIV_BITS-1:0] CLAMP     = DIV_BITS'(120);
    localparam logic [CW-1:0]       DIV_LAST  = CW'(DIV_BITS - 1);

    typedef enum logic [2:0] {IDLE, ADDR, WAIT, CHECK, DIV, DONE, HOLD} state_t;

    state_t               r_state;
    state_t               w_next;
    logic [15:0]          r_rx;
    logic [15:0]          r_ry;
    logic [6:0]           r_n;
    logic [7:0]           r_map_addr;
    logic [6:0]           r_slice;
    logic                 r_skip;
    logic [7:0]           r_divisor;
    logic [7:0]           r_div_rem;
    logic [DIV_BITS-2:0]  r_div_q;
    logic [DIV_BITS-1:0]  r_div_num;
    logic [CW-1:0]        r_div_cnt;

    logic                 w_oob;
    logic [7:0]           w_trial;
    logic                 w_ge;
    logic [7:0]           w_rem_next;
    logic [DIV_BITS-1:0]  w_q_next;
    logic                 w_div_last;
    logic [6:0]           w_q_clamped;

    // Signed range check 0..4095 on the 16-bit accumulators, done with bit tests.
    assign w_oob = r_rx[15] | (|r_rx[14:12]) | r_ry[15] | (|r_ry[14:12]);

    assign w_trial     = {r_div_rem[6:0], r_div_num[DIV_BITS-1]};
    assign w_ge        = (w_trial >= r_divisor);
    assign w_rem_next  = w_ge ? (w_trial - r_divisor) : w_trial;
    assign w_q_next    = {r_div_q, w_ge};
    assign w_div_last  = (r_div_cnt == DIV_LAST);
    assign w_q_clamped = (w_q_next > CLAMP) ? 7'd120 : w_q_next[6:0];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (begin_calc) w_next = ADDR;
            ADDR:    if (!begin_calc) w_next = IDLE;
                     else if (w_oob)  w_next = DONE;
                     else             w_next = WAIT;
            WAIT:    w_next = begin_calc ? CHECK : IDLE;
            CHECK:   if (!begin_calc)            w_next = IDLE;
                     else if (map_data)          w_next = DIV;
                     else if (r_n == LAST_STEP)  w_next = DONE;
                     else                        w_next = ADDR;
            DIV:     if (!begin_calc)  w_next = IDLE;
                     else if (w_div_last) w_next = DONE;
            DONE:    w_next = HOLD;
            HOLD:    if (!begin_calc) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rx       <= '0;
            r_ry       <= '0;
            r_n        <= '0;
            r_map_addr <= '0;
            r_slice    <= '0;
            r_skip     <= 1'b0;
            r_divisor  <= '0;
            r_div_rem  <= '0;
            r_div_q    <= '0;
            r_div_num  <= '0;
            r_div_cnt  <= '0;
        end else if (begin_calc) begin
            case (r_state)
                IDLE: begin
                    r_rx    <= {{3{playerX[12]}}, playerX};
                    r_ry    <= {{3{playerY[12]}}, playerY};
                    r_n     <= '0;
                    r_skip  <= 1'b0;
                    r_slice <= '0;
                end
                ADDR: begin
                    if (w_oob) begin
                        r_skip  <= 1'b1;
                        r_slice <= '0;
                    end else begin
                        r_map_addr <= {r_ry[11:8], r_rx[11:8]};
                    end
                end
                CHECK: begin
                    if (map_data) begin
                        r_divisor <= {1'b0, r_n} + 8'd1;
                        r_div_rem <= '0;
                        r_div_q   <= '0;
                        r_div_num <= DIVIDEND;
                        r_div_cnt <= '0;
                    end else if (r_n == LAST_STEP) begin
                        r_skip  <= 1'b1;
                        r_slice <= '0;
                    end else begin
                        r_rx <= r_rx + {{6{ray_dx[9]}}, ray_dx};
                        r_ry <= r_ry + {{6{ray_dy[9]}}, ray_dy};
                        r_n  <= r_n + 7'd1;
                    end
                end
                DIV: begin
                    // One restoring-division quotient bit per cycle, MSB first.
                    r_div_rem <= w_rem_next;
                    r_div_q   <= w_q_next[DIV_BITS-2:0];
                    r_div_num <= {r_div_num[DIV_BITS-2:0], 1'b0};
                    r_div_cnt <= r_div_cnt + CW'(1);
                    if (w_div_last) r_slice <= w_q_clamped;
                end
                default: ;
            endcase
        end
    end

    assign map_addr        = r_map_addr;
    assign slice_size      = r_slice;
    assign skip_this_slice = r_skip;
    assign end_calc        = (r_state == DONE);

endmodule

// File: tb/tb_ray_slice_caster.sv
// tb/tb_ray_slice_caster.sv - self-checking bench for ray_slice_caster
module tb_ray_slice_caster;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        begin_calc = 1'b0;
    logic [12:0] playerX = '0;
    logic [12:0] playerY = '0;
    logic [9:0]  ray_dx = '0;
    logic [9:0]  ray_dy = '0;
    logic [7:0]  map_addr;
    logic        map_data = 1'b0;
    logic [6:0]  slice_size;
    logic        skip_this_slice;
    logic        end_calc;

    bit wall_map [256];
    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        int map_id;
        int px, py, dx, dy;
        int es, esk, elat;
    } vec_t;
    vec_t vecs [9];

    ray_slice_caster dut (
        .clock(clock), .reset(reset), .begin_calc(begin_calc),
        .playerX(playerX), .playerY(playerY), .ray_dx(ray_dx), .ray_dy(ray_dy),
        .map_addr(map_addr), .map_data(map_data), .slice_size(slice_size),
        .skip_this_slice(skip_this_slice), .end_calc(end_calc)
    );

    always #10 clock = ~clock;

    always @(posedge clock) map_data <= wall_map[map_addr];

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic set_map(input int id);
        for (int i = 0; i < 256; i++) wall_map[i] = 1'b0;
        case (id)
            1: wall_map[8'h11] = 1'b1;
            2: wall_map[8'h1A] = 1'b1;
            3: wall_map[8'h01] = 1'b1;
            default: ;
        endcase
    endtask

    // Walk the ray cell by cell using position = origin + n*step.
    function automatic void model(input int px, py, dx, dy,
                                  output int slice, skip, lat);
        int x, y, q;
        for (int n = 0; n < 64; n++) begin
            x = px + n * dx;
            y = py + n * dy;
            if (x < 0 || x > 4095 || y < 0 || y > 4095) begin
                slice = 0; skip = 1; lat = 3 * n + 1;
                return;
            end
            if (wall_map[(y / 256) * 16 + (x / 256)]) begin
                q = 1920 / (n + 1);
                slice = (q > 120) ? 120 : q; skip = 0; lat = 3 * (n + 1) + 12;
                return;
            end
        end
        slice = 0; skip = 1; lat = 192;
    endfunction

    task automatic wait_end(input string name, input int es, esk, elat);
        int got = -1;
        for (int k = 0; k < 400; k++) begin
            @(posedge clock); #1;
            if (end_calc) begin got = k; break; end
        end
        chk({name, "_latency"}, got, elat);
        chk({name, "_slice"}, int'(slice_size), es);
        chk({name, "_skip"}, int'(skip_this_slice), esk);
        @(posedge clock); #1;
        chk({name, "_single_pulse"}, int'(end_calc), 0);
    endtask

    task automatic start_req(input int px, py, dx, dy);
        @(negedge clock);
        playerX = 13'(px); playerY = 13'(py);
        ray_dx = 10'(dx);  ray_dy = 10'(dy);
        begin_calc = 1'b1;
    endtask

    task automatic do_calc(input string name, input int px, py, dx, dy, es, esk, elat);
        start_req(px, py, dx, dy);
        wait_end(name, es, esk, elat);
    endtask

    task automatic release_req();
        begin_calc = 1'b0;
        @(posedge clock); @(posedge clock); #1;
    endtask

    initial begin
        int es, esk, elat, cnt, px, py, dx, dy;
        logic [6:0] s0;
        logic       k0;
        bit         stable;

        vecs[0] = '{1, 384, 384, 0, 0, 120, 0, 15};
        vecs[1] = '{2, 384, 400, 64, 0, 54, 0, 117};
        vecs[2] = '{0, 4000, 100, 64, 0, 0, 1, 7};
        vecs[3] = '{0, 100, 100, -64, 0, 0, 1, 7};
        vecs[4] = '{0, 500, 500, 0, 0, 0, 1, 192};
        vecs[5] = '{3, 4, 100, 4, 0, 30, 0, 204};
        vecs[6] = '{0, 100, 100, 0, -128, 0, 1, 4};
        vecs[7] = '{1, 100, 100, 20, 20, 120, 0, 39};
        vecs[8] = '{2, 1536, 400, 64, 0, 112, 0, 63};

        set_map(0);
        repeat (3) @(posedge clock);
        #1;
        chk("rst_map_addr", int'(map_addr), 0);
        chk("rst_slice", int'(slice_size), 0);
        chk("rst_skip", int'(skip_this_slice), 0);
        chk("rst_end_calc", int'(end_calc), 0);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            set_map(vecs[i].map_id);
            do_calc($sformatf("vec%0d", i), vecs[i].px, vecs[i].py, vecs[i].dx,
                    vecs[i].dy, vecs[i].es, vecs[i].esk, vecs[i].elat);
            release_req();
        end

        for (int i = 0; i < 25; i++) begin
            for (int a = 0; a < 256; a++) wall_map[a] = ($urandom_range(0, 11) == 0);
            px = int'($urandom_range(0, 4400)) - 200;
            py = int'($urandom_range(0, 4400)) - 200;
            if (i % 2 == 0) begin
                dx = int'($urandom_range(0, 128)) - 64;
                dy = int'($urandom_range(0, 128)) - 64;
            end else begin
                dx = int'($urandom_range(0, 1023)) - 512;
                dy = int'($urandom_range(0, 1023)) - 512;
            end
            model(px, py, dx, dy, es, esk, elat);
            do_calc($sformatf("rand%0d", i), px, py, dx, dy, es, esk, elat);
            release_req();
        end

        // Reset mid-march, then restart straight out of reset with request held.
        set_map(2);
        start_req(384, 400, 64, 0);
        repeat (20) @(posedge clock);
        #5 reset = 1'b1;
        #1;
        chk("midrst_map_addr", int'(map_addr), 0);
        chk("midrst_slice", int'(slice_size), 0);
        chk("midrst_skip", int'(skip_this_slice), 0);
        chk("midrst_end_calc", int'(end_calc), 0);
        @(negedge clock);
        reset = 1'b0;
        wait_end("after_rst", 54, 0, 117);
        release_req();

        // Drop the request while dividing.
        set_map(1);
        start_req(384, 384, 0, 0);
        repeat (10) @(posedge clock);
        #1 begin_calc = 1'b0;
        cnt = 0;
        repeat (30) begin
            @(posedge clock); #1;
            if (end_calc) cnt++;
        end
        chk("abort_no_pulse", cnt, 0);
        chk("abort_slice", int'(slice_size), 0);
        chk("abort_skip", int'(skip_this_slice), 0);
        set_map(2);
        do_calc("after_abort", 384, 400, 64, 0, 54, 0, 117);
        release_req();

        // Hold the request long after completion, then re-request after one low cycle.
        set_map(0);
        do_calc("hold", 4000, 100, 64, 0, 0, 1, 7);
        s0 = slice_size; k0 = skip_this_slice;
        cnt = 0; stable = 1'b1;
        repeat (50) begin
            @(posedge clock); #1;
            if (end_calc) cnt++;
            if (slice_size !== s0 || skip_this_slice !== k0) stable = 1'b0;
        end
        chk("hold_extra_pulses", cnt, 0);
        chk("hold_outputs_stable", int'(stable), 1);
        begin_calc = 1'b0;
        @(posedge clock); #1;
        set_map(1);
        do_calc("rerequest", 384, 384, 0, 0, 120, 0, 15);
        release_req();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
